// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ burst producers.
// The grant is held for one burst. Push and wr_data are registered. FIFO count gates acceptance.
module fifo_push_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int MAX_BURST = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     push,
  output logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH):0]   fifo_count,
  input  logic                     fifo_full,
  output logic                     overflow_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state;
  logic [IW-1:0]    last_idx;
  logic [IW-1:0]    sel_idx;
  logic             sel_found;
  logic [BW-1:0]    beat_cnt;
  logic [SW-1:0]    occupancy;
  logic             space_ok;
  logic             accept;
  logic             release_now;
  logic [WIDTH-1:0] granted_data;

  // The push already in flight is counted because the FIFO has not seen it yet.
  assign occupancy    = SW'(fifo_count) + SW'(push);
  assign space_ok     = occupancy < SW'(DEPTH);

  // While in BURST, last_idx is the index of the owner.
  assign accept       = (state == BURST) && req_valid[last_idx] && space_ok;
  assign release_now  = req_last[last_idx] || (beat_cnt == BW'(MAX_BURST - 1));
  assign granted_data = req_data[int'(last_idx)*WIDTH +: WIDTH];

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[last_idx] = 1'b1;
  end

  // Select the first valid requester, searching circularly from the slot after the last owner.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = last_idx;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!sel_found && req_valid[(int'(last_idx) + k) % NUM_REQ]) begin
        sel_found = 1'b1;
        sel_idx   = IW'((int'(last_idx) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      grant        <= '0;
      push         <= 1'b0;
      wr_data      <= '0;
      beat_cnt     <= '0;
      last_idx     <= IW'(NUM_REQ - 1);
      overflow_err <= 1'b0;
    end else begin
      push         <= accept;
      overflow_err <= overflow_err | (push & fifo_full);
      if (accept) begin
        wr_data  <= granted_data;
        beat_cnt <= beat_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (sel_found) begin
            grant    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
            last_idx <= sel_idx;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          // A forced release at MAX_BURST leaves the rest of the burst for a later grant.
          if (accept && release_now) begin
            grant <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
